// File: rtl/fifo_asym_pkg.sv
// Shared helpers for the asymmetric (wide-write / narrow-read) FIFO: ratio log2 and size derivations.
package fifo_asym_pkg;

    function automatic int ratio_log2(input int ratio);
        int r;
        r = 0;
        for (int i = 0; i < 5; i++) begin
            if ((1 << i) == ratio) r = i;
        end
        return r;
    endfunction

    function automatic int fifo_cap(input int ratio, input int depth_w);
        return ratio * (1 << depth_w);
    endfunction

    function automatic int fifo_cnt_w(input int ratio, input int depth_w);
        return depth_w + ratio_log2(ratio) + 1;
    endfunction

endpackage

// File: rtl/fifo_asym_sdp_ram.sv
// Simple dual-port RAM: wide write port, narrow synchronous read port with resettable output.
// The FIFO_DEVICE macro normally comes from parameters.v; it falls back to "simulation" here.
`ifndef FIFO_DEVICE
`define FIFO_DEVICE "simulation"
`endif

module fifo_asym_sdp_ram
    import fifo_asym_pkg::*;
#(
    parameter int DATA_R  = 16,
    parameter int RATIO   = 8,
    parameter int DEPTH_W = 8,
    localparam int LOG_R  = ratio_log2(RATIO),
    localparam int RD_AW  = DEPTH_W + LOG_R
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DEPTH_W-1:0]        wr_addr,
    input  logic [DATA_R*RATIO-1:0]   wr_data,
    input  logic                      rd_en,
    input  logic [RD_AW-1:0]          rd_addr,
    output logic [DATA_R-1:0]         rd_data
);
    localparam string DEVICE = `FIFO_DEVICE;
    localparam int    SW     = (LOG_R > 0) ? LOG_R : 1;

    logic [DEPTH_W-1:0] rd_slot;
    logic [SW-1:0]      rd_slice;

    assign rd_slot  = DEPTH_W'(rd_addr >> LOG_R);
    assign rd_slice = SW'(rd_addr & RD_AW'(RATIO - 1));

    generate
        if (DEVICE == "simulation") begin : g_behav
            logic [RATIO-1:0][DATA_R-1:0] mem [2**DEPTH_W];

            always_ff @(posedge clk) begin
                if (wr_en) mem[wr_addr] <= wr_data;
            end

            always_ff @(posedge clk) begin
                if (rst)        rd_data <= '0;
                else if (rd_en) rd_data <= mem[rd_slot][rd_slice];
            end
        end else begin : g_vendor
            // Block-RAM friendly form: full-width registered read, slice chosen after the RAM.
            logic [RATIO-1:0][DATA_R-1:0] mem [2**DEPTH_W];
            logic [RATIO-1:0][DATA_R-1:0] word_q;
            logic [SW-1:0]                slice_q;

            always_ff @(posedge clk) begin
                if (wr_en) mem[wr_addr] <= wr_data;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_q  <= '0;
                    slice_q <= '0;
                end else if (rd_en) begin
                    word_q  <= mem[rd_slot];
                    slice_q <= rd_slice;
                end
            end

            assign rd_data = word_q[slice_q];
        end
    endgenerate

endmodule

// File: rtl/ram_based_fifo_asym.sv
// Asymmetric FIFO: RATIO*DATA_R-bit writes, DATA_R-bit reads, LSB slice first.
// Define ASYM_FIFO_ERR_EN to get sticky overflow/underflow flags.
module ram_based_fifo_asym
    import fifo_asym_pkg::*;
#(
    parameter int DATA_R                 = 16,
    parameter int RATIO                  = 8,
    parameter int DEPTH_W                = 8,
    parameter int ALMOST_FULL_THRESHOLD  = 1512,
    parameter int ALMOST_EMPTY_THRESHOLD = 8,
    localparam int DATA_W = DATA_R * RATIO,
    localparam int CAP    = fifo_cap(RATIO, DEPTH_W),
    localparam int CNT_W  = fifo_cnt_w(RATIO, DEPTH_W)
) (
    input  logic              system_clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    output logic [DATA_R-1:0] o_rddata,
    output logic              o_rd_valid,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_empty,
    output logic              o_almost_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow,
    output logic              o_underflow
);
    localparam int RD_AW = DEPTH_W + ratio_log2(RATIO);

    logic [DEPTH_W-1:0] wr_ptr;
    logic [RD_AW-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               wr_acc;
    logic               rd_acc;
    logic               ram_rd_en;

    assign o_count        = count_q;
    assign o_full         = (count_q > CNT_W'(CAP - RATIO));
    assign o_empty        = (count_q == '0);
    assign o_almost_full  = (count_q >= CNT_W'(ALMOST_FULL_THRESHOLD));
    assign o_almost_empty = (count_q < CNT_W'(ALMOST_EMPTY_THRESHOLD));

    assign wr_acc    = i_wren && !o_full;
    assign rd_acc    = i_rden && !o_empty;
    assign ram_rd_en = rd_acc && !i_flush;

    // Flush wins over same-cycle traffic; the count moves by +RATIO per write, -1 per read.
    always_ff @(posedge system_clk) begin
        if (rst || i_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count_q    <= count_q + (wr_acc ? CNT_W'(RATIO) : '0) - (rd_acc ? CNT_W'(1) : '0);
            o_rd_valid <= rd_acc;
        end
    end

    fifo_asym_sdp_ram #(
        .DATA_R  (DATA_R),
        .RATIO   (RATIO),
        .DEPTH_W (DEPTH_W)
    ) u_ram (
        .clk     (system_clk),
        .rst     (rst),
        .wr_en   (wr_acc && !i_flush),
        .wr_addr (wr_ptr),
        .wr_data (i_wrdata),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr),
        .rd_data (o_rddata)
    );

`ifdef ASYM_FIFO_ERR_EN
    always_ff @(posedge system_clk) begin
        if (rst || i_flush) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wren && o_full)  o_overflow  <= 1'b1;
            if (i_rden && o_empty) o_underflow <= 1'b1;
        end
    end
`else
    assign o_overflow  = 1'b0;
    assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ram_based_fifo_asym.sv
// Randomised self-checking bench for ram_based_fifo_asym against a narrow-word queue model.
module tb_ram_based_fifo_asym;
    localparam int DATA_R = 16;
    localparam int RATIO  = 8;
    localparam int CAP    = 2048;
`ifdef ASYM_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         system_clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_flush = 1'b0;
    logic         i_wren = 1'b0;
    logic [127:0] i_wrdata = '0;
    logic         i_rden = 1'b0;
    logic [15:0]  o_rddata;
    logic         o_rd_valid, o_full, o_almost_full, o_empty, o_almost_empty;
    logic [11:0]  o_count;
    logic         o_overflow, o_underflow;

    int errors = 0;
    int checks = 0;

    logic [15:0] mq[$];
    logic        exp_valid = 1'b0;
    logic [15:0] exp_rddata = '0;
    logic        exp_ovf = 1'b0;
    logic        exp_unf = 1'b0;

    ram_based_fifo_asym dut (
        .system_clk     (system_clk),
        .rst            (rst),
        .i_flush        (i_flush),
        .i_wren         (i_wren),
        .i_wrdata       (i_wrdata),
        .i_rden         (i_rden),
        .o_rddata       (o_rddata),
        .o_rd_valid     (o_rd_valid),
        .o_full         (o_full),
        .o_almost_full  (o_almost_full),
        .o_empty        (o_empty),
        .o_almost_empty (o_almost_empty),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    always #5 system_clk = ~system_clk;

    // One clock of stimulus; the queue model is advanced from the pre-edge state.
    task automatic drive_cycle(input logic wren, input logic [127:0] wdata, input logic rden,
                               input logic flush, input logic rst_in,
                               output bit wacc, output bit racc);
        int sz;
        sz = mq.size();
        wacc = 1'b0;
        racc = 1'b0;
        i_wren = wren; i_wrdata = wdata; i_rden = rden; i_flush = flush; rst = rst_in;
        if (rst_in) begin
            mq.delete(); exp_valid = 0; exp_rddata = '0; exp_ovf = 0; exp_unf = 0;
        end else if (flush) begin
            mq.delete(); exp_valid = 0; exp_ovf = 0; exp_unf = 0;
        end else begin
            wacc = wren && (sz <= CAP - RATIO);
            racc = rden && (sz != 0);
            if (wren && !(sz <= CAP - RATIO)) exp_ovf = ERR_EN;
            if (rden && sz == 0) exp_unf = ERR_EN;
            exp_valid = racc;
            if (racc) exp_rddata = mq.pop_front();
            if (wacc) for (int i = 0; i < RATIO; i++) mq.push_back(wdata[i*DATA_R +: DATA_R]);
        end
        @(posedge system_clk);
        #1;
        i_wren = 0; i_rden = 0; i_flush = 0; rst = 0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        bit wa, ra;
        drive_cycle(1, rand128(), 1, 0, 1, wa, ra);
        checks++; if (o_count !== 12'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", o_count); end
        checks++; if (o_empty !== 1'b1 || o_almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b%b expected 11", o_empty, o_almost_empty); end
        checks++; if (o_full !== 1'b0 || o_almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b%b expected 00", o_full, o_almost_full); end
        checks++; if (o_rd_valid !== 1'b0 || o_rddata !== 16'h0) begin errors++; $display("[TB] FAIL reset_rd: got valid=%b data=%h expected 0/0000", o_rd_valid, o_rddata); end
        checks++; if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b%b expected 00", o_overflow, o_underflow); end
        drive_cycle(1, rand128(), 0, 0, 0, wa, ra);
        drive_cycle(0, '0, 1, 0, 1, wa, ra);
        checks++; if (o_rd_valid !== 1'b0 || o_count !== 12'd0) begin errors++; $display("[TB] FAIL reset_midread: got valid=%b count=%0d expected 0/0", o_rd_valid, o_count); end
    endtask

    task automatic test_slice_order();
        bit wa, ra;
        drive_cycle(0, '0, 0, 0, 1, wa, ra);
        drive_cycle(1, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 0, 0, 0, wa, ra);
        checks++; if (o_count !== 12'd8) begin errors++; $display("[TB] FAIL slice_count0: got %0d expected 8", o_count); end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(0, '0, 1, 0, 0, wa, ra);
            checks++;
            if (o_rd_valid !== 1'b1 || o_rddata !== 16'(i) || o_count !== 12'(7 - i)) begin
                errors++;
                $display("[TB] FAIL slice_read%0d: got valid=%b data=%h count=%0d expected 1/%h/%0d", i, o_rd_valid, o_rddata, o_count, 16'(i), 7 - i);
            end
        end
    endtask

    task automatic test_full_and_drain();
        bit wa, ra;
        drive_cycle(0, '0, 0, 0, 1, wa, ra);
        for (int k = 1; k <= 255; k++) drive_cycle(1, rand128(), 0, 0, 0, wa, ra);
        checks++; if (o_count !== 12'd2040 || o_full !== 1'b0 || o_almost_full !== 1'b1) begin errors++; $display("[TB] FAIL fill255: got count=%0d full=%b af=%b expected 2040/0/1", o_count, o_full, o_almost_full); end
        drive_cycle(1, rand128(), 0, 0, 0, wa, ra);
        checks++; if (o_count !== 12'd2048 || o_full !== 1'b1) begin errors++; $display("[TB] FAIL fill256: got count=%0d full=%b expected 2048/1", o_count, o_full); end
        drive_cycle(1, rand128(), 0, 0, 0, wa, ra);
        checks++; if (o_count !== 12'd2048 || o_overflow !== exp_ovf) begin errors++; $display("[TB] FAIL overflow: got count=%0d ovf=%b expected 2048/%b", o_count, o_overflow, exp_ovf); end
        drive_cycle(0, '0, 1, 0, 0, wa, ra);
        checks++; if (o_count !== 12'd2047 || o_full !== 1'b1 || o_rddata !== exp_rddata) begin errors++; $display("[TB] FAIL drain1: got count=%0d full=%b data=%h expected 2047/1/%h", o_count, o_full, o_rddata, exp_rddata); end
        for (int k = 2; k <= 7; k++) drive_cycle(0, '0, 1, 0, 0, wa, ra);
        drive_cycle(1, rand128(), 1, 0, 0, wa, ra);
        checks++; if (o_count !== 12'd2040 || o_full !== 1'b0 || o_rddata !== exp_rddata) begin errors++; $display("[TB] FAIL drain8: got count=%0d full=%b data=%h expected 2040/0/%h", o_count, o_full, o_rddata, exp_rddata); end
    endtask

    task automatic test_simul_rw_and_flush();
        bit wa, ra;
        drive_cycle(0, '0, 0, 0, 1, wa, ra);
        drive_cycle(1, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 0, 0, 0, wa, ra);
        for (int k = 0; k < 3; k++) drive_cycle(0, '0, 1, 0, 0, wa, ra);
        checks++; if (o_count !== 12'd5) begin errors++; $display("[TB] FAIL simul_pre: got %0d expected 5", o_count); end
        drive_cycle(1, rand128(), 1, 0, 0, wa, ra);
        checks++; if (o_count !== 12'd12 || o_rd_valid !== 1'b1 || o_rddata !== 16'h0003) begin errors++; $display("[TB] FAIL simul_rw: got count=%0d valid=%b data=%h expected 12/1/0003", o_count, o_rd_valid, o_rddata); end
        for (int k = 0; k < 11; k++) drive_cycle(1, rand128(), 0, 0, 0, wa, ra);
        checks++; if (o_count !== 12'd100) begin errors++; $display("[TB] FAIL flush_pre: got %0d expected 100", o_count); end
        drive_cycle(1, rand128(), 1, 1, 0, wa, ra);
        checks++; if (o_count !== 12'd0 || o_empty !== 1'b1 || o_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush: got count=%0d empty=%b valid=%b expected 0/1/0", o_count, o_empty, o_rd_valid); end
        drive_cycle(0, '0, 1, 0, 0, wa, ra);
        checks++; if (o_rd_valid !== 1'b0 || o_underflow !== exp_unf) begin errors++; $display("[TB] FAIL underflow: got valid=%b unf=%b expected 0/%b", o_rd_valid, o_underflow, exp_unf); end
    endtask

    task automatic test_random();
        bit wa, ra;
        int nw, nr, cyc;
        nw = 0; nr = 0; cyc = 0;
        drive_cycle(0, '0, 0, 0, 1, wa, ra);
        while ((nw < 300 || nr < 600) && cyc < 20000) begin
            drive_cycle((nw < 300) && ($urandom_range(0, 2) == 0), rand128(),
                        (nr < 600) && ($urandom_range(0, 2) != 0), 0, 0, wa, ra);
            nw += int'(wa);
            nr += int'(ra);
            cyc++;
            checks++;
            if (o_count !== 12'(mq.size()) || o_empty !== (mq.size() == 0) || o_full !== (mq.size() > CAP - RATIO)
                || o_almost_empty !== (mq.size() < 8) || o_almost_full !== (mq.size() >= 1512) || o_rd_valid !== exp_valid) begin
                errors++;
                $display("[TB] FAIL rand_state cyc%0d: got count=%0d e=%b f=%b ae=%b af=%b v=%b expected count=%0d v=%b",
                         cyc, o_count, o_empty, o_full, o_almost_empty, o_almost_full, o_rd_valid, mq.size(), exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (o_rddata !== exp_rddata) begin errors++; $display("[TB] FAIL rand_data cyc%0d: got %h expected %h", cyc, o_rddata, exp_rddata); end
            end
        end
        checks++;
        if (nw < 300 || nr < 600) begin errors++; $display("[TB] FAIL rand_budget: got writes=%0d reads=%0d expected 300/600", nw, nr); end
    endtask

    initial begin
        test_reset();
        test_slice_order();
        test_full_and_drain();
        test_simul_rw_and_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_based_fifo_asym.md
RAM_BASED_FIFO_ASYM -- requirements
Module: ram_based_fifo_asym

Interface
REQ-001 SHALL have parameter DATA_R, default 16, meaning narrow read-word width in bits.
REQ-002 SHALL have parameter RATIO, default 8, meaning write/read width ratio, a power of two from 1 to 16.
REQ-003 SHALL have parameter DEPTH_W, default 8, meaning log2 of the number of wide RAM slots.
REQ-004 SHALL have parameter ALMOST_FULL_THRESHOLD, default 1512, meaning the fill level, in narrow words, at which almost_full asserts.
REQ-005 SHALL have parameter ALMOST_EMPTY_THRESHOLD, default 8, meaning the fill level, in narrow words, below which almost_empty asserts.
REQ-006 SHALL derive the following: DATA_W = DATA_R*RATIO; CAP = RATIO*2^DEPTH_W; CNT_W = DEPTH_W+log2(RATIO)+1.
REQ-007 SHALL have port system_clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port i_flush, input, 1 bit: synchronous clear of the contents.
REQ-010 SHALL have ports i_wren (input, 1 bit) and i_wrdata (input, DATA_W bits): wide write request and data.
REQ-011 SHALL have ports i_rden (input, 1 bit), o_rddata (output, DATA_R bits) and o_rd_valid (output, 1 bit): narrow read request, data and data-valid.
REQ-012 SHALL have ports o_full, o_almost_full, o_empty and o_almost_empty, each an output of 1 bit: status flags.
REQ-013 SHALL have port o_count, output, CNT_W bits: current occupancy in narrow words.
REQ-014 SHALL have ports o_overflow and o_underflow, each an output of 1 bit: sticky error flags (see Configuration).

Function
REQ-015 SHALL accept a write when i_wren && !o_full; writes with o_full high SHALL be dropped.
REQ-016 SHALL accept a read when i_rden && !o_empty; reads with o_empty high SHALL be ignored.
REQ-017 SHALL drive o_full = (o_count > CAP-RATIO), so a full wide slot is always free when a write is accepted.
REQ-018 SHALL drive o_empty = (o_count == 0), with no write-to-read bypass; a word written at cycle N is readable from cycle N+1.
REQ-019 SHALL drive o_almost_full = (o_count >= ALMOST_FULL_THRESHOLD) and o_almost_empty = (o_count < ALMOST_EMPTY_THRESHOLD); all flags SHALL be combinational from registered state.
REQ-020 SHALL update o_count as +RATIO per accepted write, -1 per accepted read, and +RATIO-1 when both occur in the same cycle.
REQ-021 SHALL read each wide word out LSB slice first: bits [DATA_R-1:0], then the next DATA_R bits, and so on.
REQ-022 SHALL keep the write pointer at DEPTH_W bits and the read pointer at DEPTH_W+log2(RATIO) bits; both SHALL wrap to 0 naturally at their maximum.
REQ-023 SHALL present o_rddata, with o_rd_valid high for one cycle, exactly one cycle after an accepted read; o_rddata SHALL hold its value until the next accepted read.
REQ-024 SHALL give i_flush priority over same-cycle reads and writes: pointers and o_count SHALL go to 0, o_rd_valid SHALL go to 0 on the next cycle, and RAM contents are don't-care.
REQ-025 SHALL, when RATIO=1, behave as a symmetric FIFO.

Reset
REQ-026 SHALL, with rst high at a clock edge, set pointers=0, o_count=0, o_rd_valid=0, o_rddata=0, o_overflow=0 and o_underflow=0; the flags SHALL then read empty=1, almost_empty=1, full=0, almost_full=0.
REQ-027 SHALL, if rst is asserted mid-operation, discard any in-flight read, with o_rd_valid low on the following cycle.

Configuration
REQ-028 SHALL support macro ASYM_FIFO_ERR_EN.
- When defined: o_overflow SHALL set on i_wren && o_full, and o_underflow SHALL set on i_rden && o_empty; both are sticky and cleared only by rst or i_flush.
- When undefined: both outputs SHALL be constant 0, with no registers inferred.

Structure
REQ-029 SHALL place the RATIO-to-log2 function and the CNT_W/CAP derivation constants in the shared package fifo_asym_pkg, with the `device` selection kept in parameters.v.
REQ-030 SHALL instantiate exactly one sub-module, fifo_asym_sdp_ram: a simple dual-port RAM with a wide write port and a narrow synchronous read port, which SHALL use the behavioural model when `device == "simulation"` and the vendor RAM otherwise.

Verification (all with DATA_R=16, RATIO=8, DEPTH_W=8, CAP=2048)
REQ-031 SHALL cover this scenario: write 128'h0007_0006_0005_0004_0003_0002_0001_0000, then 8 reads -> o_rddata = 0,1,...,7 on consecutive cycles, with o_count going 8 -> 0.
REQ-032 SHALL cover this scenario: 255 writes with no reads -> o_count = 2040 and full=0; a 256th write -> o_count = 2048 and full=1; a 257th write is dropped and o_overflow=1 when ASYM_FIFO_ERR_EN is defined.
REQ-033 SHALL cover this scenario: from full, 1 read -> full stays 1 (count 2047); after 8 reads -> count 2040 and full=0; a write in the same cycle as the 8th read is rejected.
REQ-034 SHALL cover this scenario: a simultaneous write and read at count 5 -> count 12 the next cycle, and the read returns the oldest slice.
REQ-035 SHALL cover this scenario: 300 write/600 read random interleave spanning pointer wrap -> the output sequence matches the scoreboard, the o_count invariant holds, and there is no o_rd_valid while empty.
REQ-036 SHALL cover this scenario: i_flush together with i_wren and i_rden at count 100 -> the next cycle shows count 0, empty=1 and o_rd_valid=0.
